// File: rtl/regfile_32x32_pkg.sv
// Register-file constants shared with the mux32 read tree and the datapath.
// Combinational helpers only; no state.
package regfile_32x32_pkg;

  localparam int NUM_REGS     = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int REG_ZERO_IDX = 0;

  function automatic logic is_zero_idx(input logic [REG_ADDR_W-1:0] addr);
    return addr == REG_ADDR_W'(REG_ZERO_IDX);
  endfunction

endpackage

// File: rtl/regfile_32x32_mux32.sv
// One-bit 32:1 select, one instance per data bit per read port.
// Combinational, zero latency; no backpressure.
module mux32
  import regfile_32x32_pkg::*;
(
  input  logic [NUM_REGS-1:0]   d,
  input  logic [REG_ADDR_W-1:0] sel,
  output logic                  y
);

  assign y = d[sel];

endmodule

// File: rtl/regfile_32x32_wr_decoder.sv
// One-hot 5:32 write-enable decode gated by en; all-zero when addr is unknown.
// Combinational, zero latency; no backpressure.
module wr_decoder_5to32
  import regfile_32x32_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic                  en,
  output logic [NUM_REGS-1:0]   we
);

  // An equality against an unknown address is not true, so no bit is set.
  always_comb begin
    we = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (addr == REG_ADDR_W'(i))) we[i] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_32x32.sv
// 32 x WIDTH register file: one synchronous write (1-cycle latency), two combinational reads.
// Always ready, never stalls; optional same-cycle write forwarding under BYPASS.
module regfile_32x32
  import regfile_32x32_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]      rd_data_a,
  output logic [WIDTH-1:0]      rd_data_b
);

  localparam logic [NUM_REGS-1:0] ZERO_MASK =
    (ZERO_REG != 0) ? (NUM_REGS'(1) << REG_ZERO_IDX) : '0;

  logic [NUM_REGS-1:0] we_raw;
  logic [NUM_REGS-1:0] we;
  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [WIDTH-1:0]    mux_a;
  logic [WIDTH-1:0]    mux_b;
  logic                fwd_a;
  logic                fwd_b;

  wr_decoder_5to32 u_wr_dec (
    .addr (wr_addr),
    .en   (wr_en),
    .we   (we_raw)
  );

  // The zero register never sees an enable, so its flop is a constant 0 and folds away.
  assign we = we_raw & ~ZERO_MASK;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs[r] <= '0;
      end else if (we[r]) begin
        regs[r] <= wr_data;
      end
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [NUM_REGS-1:0] col;
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_col
      assign col[r] = regs[r][b];
    end

    mux32 u_mux_a (.d(col), .sel(rd_addr_a), .y(mux_a[b]));
    mux32 u_mux_b (.d(col), .sel(rd_addr_b), .y(mux_b[b]));
  end

  // Forwarding is suppressed under reset and for the zero register.
  assign fwd_a = (BYPASS != 0) && rst_n && wr_en && (wr_addr == rd_addr_a)
              && !((ZERO_REG != 0) && is_zero_idx(rd_addr_a));
  assign fwd_b = (BYPASS != 0) && rst_n && wr_en && (wr_addr == rd_addr_b)
              && !((ZERO_REG != 0) && is_zero_idx(rd_addr_b));

  assign rd_data_a = fwd_a ? wr_data : mux_a;
  assign rd_data_b = fwd_b ? wr_data : mux_b;

endmodule

// File: tb/tb_regfile_32x32.sv
// Checks three configurations (ZERO_REG/BYPASS = 1/0, 0/1, 1/1) against one array model.
module tb_regfile_32x32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] ra [3];
  logic [31:0] rb [3];

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  regfile_32x32 #(.WIDTH(32), .ZERO_REG(1), .BYPASS(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(ra[0]), .rd_data_b(rb[0])
  );
  regfile_32x32 #(.WIDTH(32), .ZERO_REG(0), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(ra[1]), .rd_data_b(rb[1])
  );
  regfile_32x32 #(.WIDTH(32), .ZERO_REG(1), .BYPASS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(ra[2]), .rd_data_b(rb[2])
  );

  // Reference: what a read of address a should return for configuration k right now.
  function automatic logic [31:0] model_rd(input int k, input logic [4:0] a);
    bit zr = (k != 1);
    bit bp = (k != 0);
    if (!rst_n) return 32'h0;
    if (zr && a == 5'd0) return 32'h0;
    if (bp && wr_en && wr_addr == a) return wr_data;
    return mem[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    if (rst_n && wr_en) mem[wr_addr] = wr_data;
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    clock_edge();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    clear_model();
    #2;
    for (int a = 0; a < 32; a++) begin
      rd_addr_a = 5'(a); rd_addr_b = 5'(31 - a);
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ra[k] !== 32'h0 || rb[k] !== 32'h0) begin
          failures++;
          $display("FAIL reset_state dut%0d addr %0d: A=%h B=%h required 0", k, a, ra[k], rb[k]);
        end
      end
    end
    // First rising edge after release must accept a write.
    @(negedge clk);
    rst_n = 1'b1; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h0BAD_F00D; rd_addr_a = 5'd4;
    clock_edge();
    wr_en = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ra[k] !== 32'h0BAD_F00D) begin
        failures++;
        $display("FAIL reset_release dut%0d: got %h required 0badf00d", k, ra[k]);
      end
    end
    write_reg(5'd9, 32'h1234_5678);
    // Reset dropped mid-cycle must clear everything immediately.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    for (int a = 0; a < 32; a++) begin
      rd_addr_a = 5'(a); rd_addr_b = 5'(a);
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ra[k] !== 32'h0 || rb[k] !== 32'h0) begin
          failures++;
          $display("FAIL midcycle_reset dut%0d addr %0d: A=%h B=%h required 0", k, a, ra[k], rb[k]);
        end
      end
    end
    // A write under held reset is lost, and is not forwarded either.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFE_F00D; rd_addr_a = 5'd3;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ra[k] !== 32'h0) begin
        failures++;
        $display("FAIL reset_write_fwd dut%0d: got %h required 0", k, ra[k]);
      end
    end
    clock_edge();
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ra[k] !== 32'h0) begin
        failures++;
        $display("FAIL reset_write_lost dut%0d: got %h required 0", k, ra[k]);
      end
    end
  endtask

  task automatic test_fill_readback();
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'hA5A5_0000 + 32'(i));
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i);
      #1;
      for (int k = 0; k < 3; k++) begin
        logic [31:0] ea = (i == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(i);
        logic [31:0] eb = (i == 31) ? 32'h0 : 32'hA5A5_0000 + 32'(31 - i);
        checks++;
        if (ra[k] !== ea || rb[k] !== eb) begin
          failures++;
          $display("FAIL fill_readback dut%0d A[%0d]=%h req %h B[%0d]=%h req %h",
                   k, i, ra[k], ea, 31 - i, rb[k], eb);
        end
      end
    end
  endtask

  task automatic test_zero_reg();
    logic [31:0] req [3];
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    #1;
    req[0] = 32'h0; req[1] = 32'hFFFF_FFFF; req[2] = 32'h0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ra[k] !== req[k]) begin
        failures++;
        $display("FAIL zero_reg_during_write dut%0d: got %h required %h", k, ra[k], req[k]);
      end
    end
    clock_edge();
    wr_en = 1'b0;
    #1;
    req[1] = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ra[k] !== req[k] || rb[k] !== req[k]) begin
        failures++;
        $display("FAIL zero_reg_after_write dut%0d: A=%h B=%h required %h", k, ra[k], rb[k], req[k]);
      end
    end
  endtask

  task automatic test_read_during_write();
    write_reg(5'd5, 32'h1111_1111);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h2222_2222; rd_addr_a = 5'd5; rd_addr_b = 5'd6;
    #1;
    checks++;
    if (ra[0] !== 32'h1111_1111) begin
      failures++;
      $display("FAIL rdw_nobypass_before dut0: got %h required 11111111", ra[0]);
    end
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (ra[k] !== 32'h2222_2222 || rb[k] !== 32'hA5A5_0006) begin
        failures++;
        $display("FAIL rdw_bypass dut%0d: A=%h req 22222222 B=%h req a5a50006", k, ra[k], rb[k]);
      end
    end
    clock_edge();
    wr_en = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ra[k] !== 32'h2222_2222) begin
        failures++;
        $display("FAIL rdw_after_edge dut%0d: got %h required 22222222", k, ra[k]);
      end
    end
  endtask

  task automatic test_write_disable();
    @(negedge clk);
    wr_en = 1'b0; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF; rd_addr_a = 5'd7; rd_addr_b = 5'd7;
    clock_edge();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ra[k] !== 32'hA5A5_0007 || rb[k] !== 32'hA5A5_0007) begin
        failures++;
        $display("FAIL write_disable dut%0d: A=%h B=%h required a5a50007", k, ra[k], rb[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      wr_en     = ($urandom_range(0, 3) != 0);
      wr_addr   = 5'($urandom_range(0, 31));
      wr_data   = $urandom;
      rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      #1;
      for (int k = 0; k < 3; k++) begin
        logic [31:0] ea = model_rd(k, rd_addr_a);
        logic [31:0] eb = model_rd(k, rd_addr_b);
        checks++;
        if (ra[k] !== ea || rb[k] !== eb) begin
          failures++;
          if (failures < 20)
            $display("FAIL random cyc %0d dut%0d A[%0d]=%h req %h B[%0d]=%h req %h",
                     c, k, rd_addr_a, ra[k], ea, rd_addr_b, rb[k], eb);
        end
      end
      clock_edge();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_readback();
    test_zero_reg();
    test_read_during_write();
    test_write_disable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
